// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 9-bit
// pebble instruction set. It owns the PC and the instruction register, drives
// the register-file write strobe and the data-memory handshake, and halts on
// the done-type branch or on a data-memory timeout.
//
// Optional build macro: INSTR_SEQ_PERF_EN adds 32-bit saturating cycle_count
// and instr_count outputs. Without it those ports do not exist.
module instr_sequencer #(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15   // must be >= 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rdata,
  output logic [8:0]      ir,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done,
  output logic            error
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [31:0]     cycle_count,
  output logic [31:0]     instr_count
`endif
);

  // Sequencer states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Instruction classes taken from ir[8:7].
  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_MEM = 2'b10;

  // The stall counter only needs to reach MEM_TIMEOUT-1; the +1 keeps the
  // width non-zero when MEM_TIMEOUT is 1.
  localparam int               CNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] stall_cnt;

  logic start_ok;     // start accepted this cycle
  logic mem_done;     // data-memory access completes this cycle
  logic exec_done;    // non-memory instruction leaves EXEC this cycle
  logic timeout_hit;  // last allowed MEM cycle passes without an ack

  // PC increment wraps naturally at 2^PC_W.
  assign pc_inc = pc + PC_W'(1);

  // Event decode shared by next-state logic, flags and counters.
  always_comb begin
    start_ok    = start && ((state == S_IDLE) || (state == S_HALT));
    mem_done    = (state == S_MEM) && mem_ack;
    exec_done   = (state == S_EXEC) && (ir[8:7] != OP_MEM);
    timeout_hit = (state == S_MEM) && !mem_ack && (stall_cnt == STALL_LAST);
  end

  // Next-state and next-PC selection.
  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = start_pc;
        end
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (ir[8:7])
          OP_R, OP_I: begin
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
          end
          OP_MEM: state_nxt = S_MEM;
          default: begin
            if (ir[6]) begin
              state_nxt = S_HALT;
            end else begin
              pc_nxt    = branch_taken ? branch_target : pc_inc;
              state_nxt = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end else if (stall_cnt == STALL_LAST) begin
          state_nxt = S_HALT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and PC registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Instruction register captures the ROM word at the end of DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (state == S_DECODE) begin
      ir <= imem_rdata;
    end
  end

  // MEM stall counter; held at zero outside MEM so it starts clean on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state != S_MEM) begin
      stall_cnt <= '0;
    end else if (!mem_ack && (stall_cnt != STALL_LAST)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (start_ok) begin
      error <= 1'b0;
    end else if (timeout_hit) begin
      error <= 1'b1;
    end
  end

  // Registered done flag, rising on the HALT-entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state_nxt == S_HALT);
    end
  end

  // Combinational outputs derived from state and ir; mem_req falls with the
  // asynchronous state reset.
  always_comb begin
    imem_addr = pc;
    busy      = (state == S_FETCH) || (state == S_DECODE) ||
                (state == S_EXEC)  || (state == S_MEM);
    mem_req   = (state == S_MEM);
    mem_we    = (state == S_MEM) && !ir[6];
    reg_we    = ((state == S_EXEC) && !ir[8]) || (mem_done && ir[6]);
  end

`ifdef INSTR_SEQ_PERF_EN
  // Saturating busy-cycle and completed-instruction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (start_ok) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (busy && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if ((exec_done || mem_done) && (instr_count != '1)) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/execute sequencer for the 9-bit pebble instruction set. Drives the instruction-memory address, captures each fetched word into the instruction register, and steps every instruction through FETCH, DECODE, EXEC and, for memory operations, MEM. Issues register-file write enables and the data-memory request/acknowledge handshake, selects the next PC from the datapath's branch result, and halts on the branch-type done flag. Sits between instruction memory, the decoder (which reads `ir`), the datapath and data memory.

## Interface
Parameters:
- `PC_W`, default 10: program counter / instruction address width.
- `MEM_TIMEOUT`, default 15: maximum cycles spent in MEM waiting for `mem_ack`; minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- `start_pc`  in  PC_W  PC loaded on an accepted `start`.
- `imem_addr`  out  PC_W  instruction address; always equals the internal PC.
- `imem_rdata`  in  9  synchronous-ROM data, valid the cycle after the address is presented.
- `ir`  out  9  instruction register, feeds the decoder.
- `branch_taken`  in  1  datapath compare result; sampled in EXEC for type 11.
- `branch_target`  in  PC_W  branch destination; sampled in EXEC for type 11.
- `reg_we`  out  1  register-file write strobe, one cycle.
- `mem_req`  out  1  data-memory request, held until acknowledged.
- `mem_we`  out  1  store qualifier, valid while `mem_req`=1.
- `mem_ack`  in  1  data-memory completion.
- `busy`  out  1  high in FETCH, DECODE, EXEC and MEM.
- `done`  out  1  high in HALT.
- `error`  out  1  sticky memory-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: accepted `start` loads `pc`=`start_pc`, then FETCH.
- FETCH: `imem_addr`=`pc`, then DECODE.
- DECODE: `ir`<=`imem_rdata` at the end of the cycle, then EXEC.
- EXEC, decoded from `ir[8:7]`:
  - 00 / 01 (R / I): `reg_we`=1 for this cycle; `pc`<=`pc`+1; then FETCH.
  - 10 (memory): go to MEM; `pc` unchanged.
  - 11, `ir[6]`=1 (done): go to HALT; `pc` unchanged; no `reg_we`.
  - 11, `ir[6]`=0: `pc`<=`branch_taken` ? `branch_target` : `pc`+1; then FETCH.
- MEM:
  - `mem_req`=1 and `mem_we`=~`ir[6]`.
  - On the `mem_ack` cycle: `reg_we`=`ir[6]` (load writes back), `pc`<=`pc`+1, deassert `mem_req` next cycle, go to FETCH.
  - Stall counter is cleared on MEM entry. If `MEM_TIMEOUT` cycles elapse with no ack: `error`<=1, go to HALT, `pc` unchanged.
- HALT: accepted `start` reloads `pc`, clears `error`, goes to FETCH.
- `start` is ignored in every other state.
- PC arithmetic is modulo 2^PC_W: `pc`+1 at all-ones wraps to 0.
- `mem_ack` outside MEM is ignored.

## Timing
- Reset (asynchronous, while `rst_n`=0): state IDLE; `pc`, `imem_addr`, `ir` = 0; `reg_we`, `mem_req`, `mem_we`, `busy`, `done`, `error` = 0.
- Reset mid-instruction aborts immediately; `mem_req` drops asynchronously.
- Latencies from FETCH entry:
  - R/I/branch: 3 cycles per instruction.
  - Memory: 4 cycles when `mem_ack` arrives on the first MEM cycle; each wait cycle adds 1.
- `reg_we` is combinational from state and `ir`. It is asserted exactly on the EXEC cycle (R/I) or the ack cycle (load).
- `done` and `error` are registered and change on the HALT-entry edge.
- `start` and `mem_ack` arriving in the same cycle cannot occur: `start` is honoured only in IDLE/HALT, and `mem_ack` only in MEM.

## Configuration
- `INSTR_SEQ_PERF_EN`:
  - Defined: adds output `cycle_count` (32 bits) and output `instr_count` (32 bits).
    - Both clear on an accepted `start` and on reset.
    - `cycle_count` increments every cycle `busy`=1.
    - `instr_count` increments on each instruction completion (EXEC exit to FETCH or HALT, or MEM ack).
    - Both saturate at all-ones.
  - Undefined: neither port exists; all other behaviour is identical.

## Test plan
- Reset with `start_pc`=5, then `start`. ROM[5]=R-type 9'b000_0011_01. Expected: `imem_addr`=5 in FETCH; `ir`=9'h00D in EXEC; `reg_we` high for one cycle; next FETCH at `imem_addr`=6.
- Load 9'b10_1_01_10_00 with `mem_ack` delayed 3 cycles. Expected: `mem_req`=1 and `mem_we`=0 for 4 cycles; `reg_we`=1 on the ack cycle only; next `imem_addr`=pc+1.
- Store with no `mem_ack` for 15 cycles. Expected: `error`=1, `done`=1, `pc` unchanged. A following `start` clears `error`.
- Branch 9'b11_0_0000_00 at pc 7. With `branch_taken`=1 and `branch_target`=2, next fetch is 2. With `branch_taken`=0, next fetch is 8.
- Halt 9'b11_1_000000 at pc 3. Expected: `done`=1, `busy`=0, `imem_addr` stays 3. `start` pulses in other states are ignored.
- R-type at pc 1023 with `PC_W`=10: next fetch wraps to 0. Assert `rst_n` mid-MEM: `mem_req` drops immediately and state returns to IDLE.
